// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file and trap controller:
// CSR addresses, operation encoding, cause codes and mstatus bit positions.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [4:0] CAUSE_MTI    = 5'd7;
  localparam logic [4:0] CAUSE_MEI    = 5'd11;
  localparam logic [4:0] CAUSE_LOCAL0 = 5'd16;

  // New CSR value for a read-modify-write operation.
  function automatic logic [31:0] csr_update(input csr_op_e op,
                                             input logic [31:0] old_val,
                                             input logic [31:0] operand);
    logic [31:0] res;
    case (op)
      CSR_WRITE: res = operand;
      CSR_SET:   res = old_val | operand;
      CSR_CLEAR: res = old_val & ~operand;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for a vector of asynchronous level-sensitive
// interrupt lines. Each bit is synchronised independently.
module irq_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [STAGES-1:0][W-1:0] chain;

  // Shift every line through STAGES flops; chain[0] is the metastable stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
    end
  end

  assign dout = chain[STAGES-1];

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller for the 3-stage RV32 core.
// Reads are combinational and return the pre-write value; writes, trap entry,
// mret and counter updates happen on the rising clock edge. Same-cycle
// priority is exception > interrupt > mret > CSR write.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int          NUM_IRQ     = 4,
  parameter int          SYNC_STAGES = 2,
  parameter int          CNT_W       = 64,
  parameter logic [31:0] MTVEC_RST   = 32'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        pc,
  input  logic [11:0]        addr,
  input  logic [31:0]        wdata,
  input  logic [1:0]         csr_op,
  input  logic               reg_wr,
  input  logic               reg_rd,
  input  logic               exc_valid,
  input  logic [3:0]         exc_cause,
  input  logic               is_mret,
  input  logic               instr_ret,
  input  logic               timer_irq,
  input  logic               ext_irq,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [31:0]        csr_rdata,
  output logic [31:0]        epc_evec,
  output logic               redirect,
  output logic               illegal_csr
);

  // Implemented interrupt bits: MEI, MTI and the local lines at [16+i].
  localparam logic [31:0] IRQ_MASK =
    32'h0000_0880 | ({{(32-NUM_IRQ){1'b0}}, {NUM_IRQ{1'b1}}} << 16);

  csr_op_e op;
  assign op = csr_op_e'(csr_op);

  logic               mstatus_mie, mstatus_mpie;
  logic [31:0]        mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [CNT_W-1:0]   mcycle_q, minstret_q;
  logic [63:0]        mcycle_x, minstret_x, cyc_nxt, ret_nxt;
  logic [NUM_IRQ+1:0] irq_s;
  logic [31:0]        mip_val, mstatus_val, rd_val, wr_val, pend, evec_base, trap_vec;
  logic               known, wr_req, wr_mod, ill, int_req, trap, take_mret, csr_we;
  logic [4:0]         int_code, trap_code;

  // Bit 0 = ext_irq, bit 1 = timer_irq, bits 2.. = local lines.
  irq_sync #(.W(NUM_IRQ + 2), .STAGES(SYNC_STAGES)) u_irq_sync (
    .clk  (clk),
    .reset(reset),
    .din  ({irq, timer_irq, ext_irq}),
    .dout (irq_s)
  );

  assign mcycle_x   = 64'(mcycle_q);
  assign minstret_x = 64'(minstret_q);

  // Assemble mip and mstatus read views from the synchronised lines and flags.
  always_comb begin
    mip_val     = '0;
    mip_val[11] = irq_s[0];
    mip_val[7]  = irq_s[1];
    for (int i = 0; i < NUM_IRQ; i++) mip_val[16+i] = irq_s[2+i];
    mstatus_val               = '0;
    mstatus_val[12:11]        = 2'b11;
    mstatus_val[MSTATUS_MPIE] = mstatus_mpie;
    mstatus_val[MSTATUS_MIE]  = mstatus_mie;
  end

  // Read mux; unknown addresses read 0 and flag as unimplemented.
  always_comb begin
    rd_val = '0;
    known  = 1'b1;
    case (addr)
      CSR_MSTATUS:   rd_val = mstatus_val;
      CSR_MIE:       rd_val = mie_q;
      CSR_MTVEC:     rd_val = mtvec_q;
      CSR_MSCRATCH:  rd_val = mscratch_q;
      CSR_MEPC:      rd_val = mepc_q;
      CSR_MCAUSE:    rd_val = mcause_q;
      CSR_MIP:       rd_val = mip_val;
      CSR_MCYCLE:    rd_val = mcycle_x[31:0];
      CSR_MCYCLEH:   rd_val = mcycle_x[63:32];
      CSR_MINSTRET:  rd_val = minstret_x[31:0];
      CSR_MINSTRETH: rd_val = minstret_x[63:32];
      default:       known  = 1'b0;
    endcase
  end

  // set/clear with a zero operand is a pure read and never modifies state.
  assign wr_req = reg_wr && (op != CSR_NONE);
  assign wr_mod = reg_wr && ((op == CSR_WRITE) || ((op != CSR_NONE) && (wdata != '0)));
  assign ill    = ((reg_rd || wr_req) && !known) || (wr_mod && (addr == CSR_MIP));
  assign wr_val = csr_update(op, rd_val, wdata);

  assign pend      = mip_val & mie_q;
  assign int_req   = mstatus_mie && (pend != '0);
  assign trap      = exc_valid || int_req;
  assign take_mret = is_mret && !trap;
  assign csr_we    = wr_mod && known && !ill && !trap && !is_mret;

  // Fixed-priority interrupt select: MEI, then MTI, then lowest local index.
  always_comb begin
    int_code = CAUSE_MEI;
    if (pend[11]) begin
      int_code = CAUSE_MEI;
    end else if (pend[7]) begin
      int_code = CAUSE_MTI;
    end else begin
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
        if (pend[16+i]) int_code = CAUSE_LOCAL0 + 5'(i);
      end
    end
  end

  assign trap_code = exc_valid ? {1'b0, exc_cause} : int_code;
  assign evec_base = {mtvec_q[31:2], 2'b00};
  assign trap_vec  = (mtvec_q[0] && !exc_valid) ? evec_base + {25'b0, int_code, 2'b00}
                                                 : evec_base;

  // Outputs are forced quiet while reset is held, even mid-trap.
  assign redirect    = reset && (trap || is_mret);
  assign epc_evec    = !reset ? '0 : trap ? trap_vec : is_mret ? mepc_q : '0;
  assign illegal_csr = reset && ill;
  assign csr_rdata   = (reset && reg_rd) ? rd_val : '0;

  // mstatus interrupt-enable stack: trap pushes, mret pops, else CSR write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (trap) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (take_mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (csr_we && (addr == CSR_MSTATUS)) begin
      mstatus_mie  <= wr_val[MSTATUS_MIE];
      mstatus_mpie <= wr_val[MSTATUS_MPIE];
    end
  end

  // Plain registers; trap entry owns mepc/mcause ahead of software writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (trap) begin
      mepc_q   <= pc & 32'hFFFF_FFFC;
      mcause_q <= {!exc_valid, 26'b0, trap_code};
    end else if (csr_we) begin
      case (addr)
        CSR_MIE:      mie_q      <= wr_val & IRQ_MASK;
        CSR_MTVEC:    mtvec_q    <= wr_val & 32'hFFFF_FFFD;
        CSR_MSCRATCH: mscratch_q <= wr_val;
        CSR_MEPC:     mepc_q     <= wr_val & 32'hFFFF_FFFC;
        CSR_MCAUSE:   mcause_q   <= wr_val;
        default:      ;
      endcase
    end
  end

  // Counter next values: a written half takes the CSR value, the other half
  // follows the normal increment/hold path.
  always_comb begin
    cyc_nxt = mcycle_x + 64'd1;
    ret_nxt = instr_ret ? minstret_x + 64'd1 : minstret_x;
    if (csr_we) begin
      case (addr)
        CSR_MCYCLE:    cyc_nxt[31:0]  = wr_val;
        CSR_MCYCLEH:   cyc_nxt[63:32] = wr_val;
        CSR_MINSTRET:  ret_nxt[31:0]  = wr_val;
        CSR_MINSTRETH: ret_nxt[63:32] = wr_val;
        default:       ;
      endcase
    end
  end

  // Counters wrap naturally by truncation to CNT_W bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= cyc_nxt[CNT_W-1:0];
      minstret_q <= ret_nxt[CNT_W-1:0];
    end
  end

endmodule
